// File: rtl/hazard_scoreboard_pkg.sv
// Shared opcode constants, FSM encoding and scoreboard entry type for the
// hazard scoreboard and the main control decoder.
package hazard_scoreboard_pkg;

  localparam int unsigned OpW  = 4;
  localparam int unsigned RegW = 2;

  localparam logic [OpW-1:0] OpAdd  = 4'b0000;
  localparam logic [OpW-1:0] OpSub  = 4'b0001;
  localparam logic [OpW-1:0] OpAnd  = 4'b0010;
  localparam logic [OpW-1:0] OpOr   = 4'b0011;
  localparam logic [OpW-1:0] OpAddi = 4'b0100;
  localparam logic [OpW-1:0] OpLw   = 4'b0101;
  localparam logic [OpW-1:0] OpSw   = 4'b0110;
  localparam logic [OpW-1:0] OpSlt  = 4'b0111;
  localparam logic [OpW-1:0] OpBeq  = 4'b1000;
  localparam logic [OpW-1:0] OpBne  = 4'b1001;

  localparam logic [7:0] StallCntMax = 8'hFF;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } hs_state_e;

  typedef struct packed {
    logic            valid;
    logic [RegW-1:0] dest;
  } sb_entry_t;

endpackage

// File: rtl/hazard_decode.sv
// Combinational register-usage decode of the IF/ID instruction: which source
// fields are read and which field (if any) is written.
module hazard_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [15:0]     id_ir,
  output logic            reads_rs,
  output logic            reads_rt,
  output logic            writes,
  output logic [RegW-1:0] dest
);

  logic [OpW-1:0] op;
  logic           unused_bits;

  assign op          = id_ir[15:12];
  assign unused_bits = ^{id_ir[11:10], id_ir[5:0]};

  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    writes   = 1'b0;
    dest     = id_ir[7:6];
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpSlt: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
        writes   = 1'b1;
        dest     = id_ir[7:6];
      end
      OpAddi, OpLw: begin
        reads_rs = 1'b1;
        writes   = 1'b1;
        dest     = id_ir[9:8];
      end
      OpSw, OpBeq, OpBne: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks destinations of in-flight writes after ID and
// stalls or flushes the front end. State advances on the falling clock edge.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] id_ir,
  input  logic        id_valid,
  input  logic        ex_branch_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [7:0]  stall_cnt
);

  hs_state_e                  state_q, state_d;
  sb_entry_t [DEPTH-1:0]      entries_q, entries_d;
  logic [7:0]                 stall_cnt_q, stall_cnt_d;

  logic            reads_rs, reads_rt, writes;
  logic [RegW-1:0] dest, rs, rt;
  logic            hazard, issue;

  hazard_decode u_decode (
    .id_ir    (id_ir),
    .reads_rs (reads_rs),
    .reads_rt (reads_rt),
    .writes   (writes),
    .dest     (dest)
  );

  assign rs = id_ir[11:10];
  assign rt = id_ir[9:8];

  // $0 is never pending: a read of $0 cannot match, and writes to it are dropped below.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entries_q[i].valid) begin
        if (reads_rs && (rs != '0) && (rs == entries_q[i].dest)) hazard = 1'b1;
        if (reads_rt && (rt != '0) && (rt == entries_q[i].dest)) hazard = 1'b1;
      end
    end
    hazard = hazard & id_valid;
  end

  assign issue = !ex_branch_taken && !hazard;

  always_comb begin
    for (int i = 1; i < int'(DEPTH); i++) begin
      entries_d[i] = entries_q[i-1];
    end
    entries_d[0].valid = issue && id_valid && writes && (dest != '0);
    entries_d[0].dest  = entries_d[0].valid ? dest : '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ex_branch_taken && hazard && (stall_cnt_q != StallCntMax)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      entries_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      entries_q   <= entries_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // FLUSH re-evaluates hazards exactly like RUN; a taken branch wins from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   state_d = hazard ? StStall : StRun;
      StStall: state_d = hazard ? StStall : StRun;
      StFlush: state_d = hazard ? StStall : StRun;
      default: state_d = StRun;
    endcase
    if (ex_branch_taken) state_d = StFlush;
  end

  // Outputs are Mealy on hazard/branch in every state; reset forces the run values.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (!reset) begin
      if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (hazard) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
